// File: rtl/hc165_reader_if.sv
// Bus between the 74HC165 chain reader and its surroundings: scan request,
// serial data from the chain, the '165 control pins and the captured word.
interface hc165_reader_if #(
    parameter int CHAIN_BYTES = 1
);
    localparam int N = 8 * CHAIN_BYTES;

    logic         start;
    logic         q7;
    logic         pl_n;
    logic         cp;
    logic         ce_n;
    logic [N-1:0] data;
    logic         data_vld;
    logic         changed;
    logic         busy;

    // Requesting side plus the '165 chain: issues start, supplies q7.
    modport master (
        output start,
        output q7,
        input  pl_n,
        input  cp,
        input  ce_n,
        input  data,
        input  data_vld,
        input  changed,
        input  busy
    );

    // Reader side: drives the '165 pins and publishes the captured word.
    modport slave (
        input  start,
        input  q7,
        output pl_n,
        output cp,
        output ce_n,
        output data,
        output data_vld,
        output changed,
        output busy
    );
endinterface

// File: rtl/hc165_reader.sv
// Scans a chain of 74HC165 shift registers: parallel-load pulse, then
// 8*CHAIN_BYTES bits shifted in MSB-first, result published with a
// one-cycle valid strobe and a changed flag. All outputs are registered.
module hc165_reader #(
    parameter int CHAIN_BYTES = 1,
    parameter int CLK_DIV     = 25
) (
    input  logic          clk,
    input  logic          rst,
    hc165_reader_if.slave bus
);
    localparam int N  = 8 * CHAIN_BYTES;
    localparam int DW = $clog2(CLK_DIV);
    localparam int BW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [DW-1:0]  div_q, div_d;
    logic           phase_q, phase_d;   // LOAD: which half; SHIFT: cp level
    logic [BW-1:0]  bit_q, bit_d;
    logic [N-1:0]   sr_q, sr_d;
    logic [N-1:0]   data_d;
    logic           vld_d;
    logic           chg_d;
    logic           q7_meta, q7_s;
    logic           div_last;

    // Two-flop synchronizer for the asynchronous serial input.
    always_ff @(posedge clk) begin
        if (rst) begin
            q7_meta <= 1'b0;
            q7_s    <= 1'b0;
        end else begin
            q7_meta <= bus.q7;
            q7_s    <= q7_meta;
        end
    end

    assign div_last = (div_q == DW'(CLK_DIV - 1));

    // Next-state, counters, shift register and capture decisions.
    always_comb begin
        state_d = state_q;
        div_d   = div_q + 1'b1;
        phase_d = phase_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        data_d  = bus.data;
        vld_d   = 1'b0;
        chg_d   = 1'b0;
        case (state_q)
            IDLE: begin
                div_d   = '0;
                phase_d = 1'b0;
                bit_d   = '0;
                if (bus.start) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // Load lasts two divider periods, tracked by phase.
                if (div_last) begin
                    div_d = '0;
                    if (phase_q) begin
                        state_d = SHIFT;
                        phase_d = 1'b0;
                    end else begin
                        phase_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (div_last) begin
                    div_d = '0;
                    if (!phase_q) begin
                        sr_d = {sr_q[N-2:0], q7_s};
                        if (bit_q == BW'(N - 1)) begin
                            // Last bit: no high phase, capture straight away
                            // so data and data_vld appear together in DONE.
                            state_d = DONE;
                            data_d  = sr_d;
                            vld_d   = 1'b1;
                            chg_d   = (sr_d != bus.data);
                        end else begin
                            phase_d = 1'b1;
                        end
                    end else begin
                        phase_d = 1'b0;
                        bit_d   = bit_q + 1'b1;
                    end
                end
            end
            DONE: begin
                div_d   = '0;
                state_d = IDLE;
            end
            default: begin
                div_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State/counter registers and outputs registered from next-state values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            div_q        <= '0;
            phase_q      <= 1'b0;
            bit_q        <= '0;
            sr_q         <= '0;
            bus.pl_n     <= 1'b1;
            bus.cp       <= 1'b0;
            bus.ce_n     <= 1'b1;
            bus.data     <= '0;
            bus.data_vld <= 1'b0;
            bus.changed  <= 1'b0;
            bus.busy     <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            phase_q      <= phase_d;
            bit_q        <= bit_d;
            sr_q         <= sr_d;
            bus.pl_n     <= (state_d != LOAD);
            bus.cp       <= (state_d == SHIFT) && phase_d;
            bus.ce_n     <= (state_d != SHIFT);
            bus.data     <= data_d;
            bus.data_vld <= vld_d;
            bus.changed  <= chg_d;
            bus.busy     <= (state_d != IDLE);
        end
    end
endmodule

// File: doc/hc165_reader.md
# hc165_reader

Serial input reader for a chain of 74HC165 parallel-in/serial-out shift registers. It is the receive-side counterpart of the board's 74HC595 display output path. On each `start` pulse it drives the '165 load and clock pins, shifts in `8*CHAIN_BYTES` bits MSB-first from `q7`, and presents the captured word with a one-cycle valid strobe plus a change flag. It sits beside the key filters and feeds switch/key banks into the data generator logic.

## Interface
- `CHAIN_BYTES`, default 1: number of cascaded '165 devices; `N = 8*CHAIN_BYTES` bits per scan.
- `CLK_DIV`, default 25: system clocks per serial half-period. Legal range is `CLK_DIV >= 4`.
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle scan request; accepted only when `busy=0`.
- `q7`  in  1  serial data from the '165 chain (asynchronous to `clk`).
- `pl_n`  out  1  '165 parallel load, active low.
- `cp`  out  1  '165 shift clock; the '165 shifts on the rising edge.
- `ce_n`  out  1  '165 clock inhibit, active low.
- `data`  out  N  last captured word; the first bit shifted in is `data[N-1]`.
- `data_vld`  out  1  one-cycle strobe; `data` is updated in the same cycle.
- `changed`  out  1  one-cycle strobe coincident with `data_vld` when the new word differs from the previous `data`.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- All outputs are registered.
- `q7` passes through a 2-flop synchronizer (`q7_s`) before use.
- A divider counter runs 0..CLK_DIV-1 and is cleared on every state entry.
- State machine (IDLE, LOAD, SHIFT, DONE):
  - **IDLE:** `pl_n=1`, `cp=0`, `ce_n=1`. Goes to LOAD when `start=1`.
  - **LOAD:** `pl_n=0`, `cp=0`, `ce_n=1` for exactly `2*CLK_DIV` cycles, then goes to SHIFT.
  - **SHIFT:** `pl_n=1`, `ce_n=0`. A bit counter runs 0..N-1. Each bit has a low phase of CLK_DIV cycles with `cp=0`.
    - On the last cycle of the low phase, `q7_s` is shifted into the LSB of the shift register, which shifts left.
    - For bits 0..N-2, a high phase of CLK_DIV cycles with `cp=1` follows, then the bit counter increments.
    - After sampling bit N-1 there is no high phase. The block goes straight to DONE.
    - Exactly N-1 rising edges of `cp` occur per scan.
  - **DONE:** lasts one cycle. `ce_n=1`, `cp=0`. In this cycle:
    - `data <= shift register`, `data_vld=1`.
    - `changed=1` if the new word differs from the old `data`.
    - Then goes to IDLE.
- `changed` compares against the `data` reset value (0) on the first scan after reset.
- `start` while `busy=1`, including in the DONE cycle, is ignored and is not queued.
- `rst` asserted in any state, including mid-scan:
  - next cycle is IDLE with all outputs at reset values;
  - no `data_vld` for the aborted scan;
  - the partial shift contents are discarded.

## Timing
- Reset values: `pl_n=1`, `cp=0`, `ce_n=1`, `data=0`, `data_vld=0`, `changed=0`, `busy=0`.
- `start` sampled high at cycle t in IDLE:
  - `busy=1` and `pl_n=0` from t+1 through t+2*CLK_DIV.
  - First low phase begins at t+1+2*CLK_DIV.
  - `data_vld` is high at exactly t+1+(2N+1)*CLK_DIV.
  - Defaults (N=8, CLK_DIV=25): `data_vld` at t+426.
- `busy` falls in the cycle after `data_vld`. The earliest next accepted `start` is that cycle.
- Sampling point: bit k is sampled `2 + CLK_DIV` or more cycles after the preceding `cp` edge. This allows for '165 propagation delay plus the synchronizer latency.
- `cp` period is `2*CLK_DIV` cycles: 1 MHz at the defaults.

## Test plan
- Reset: hold `rst` for 3 cycles, then release → all outputs equal their reset values, and no `cp` edge occurs without `start`.
- '165 model loaded with 0xA5, defaults, `start` at t → `pl_n` low for 50 cycles, 7 `cp` rising edges, `data=0xA5` with `data_vld` and `changed` high at t+426 only.
- Repeat the 0xA5 scan → `data_vld=1`, `changed=0`. Then a scan with 0xA4 → `changed=1`.
- `CHAIN_BYTES=2`, near chip 0x12, far chip 0x34, `CLK_DIV=4` → `data=16'h1234`, 15 `cp` rising edges, `data_vld` at t+1+33*4 = t+133.
- `start` pulsed during LOAD, during SHIFT, and in the DONE cycle → exactly one scan, one `data_vld`.
- `rst` asserted at bit 4 of a scan, then `start` issued again → the aborted scan produces no `data_vld`. Outputs are at reset values the cycle after `rst`, and the new scan returns the correct word at the nominal latency.
